serial_adder_fsm: RTL

Bit-serial ripple adder built around a single full-adder cell and a registered carry. It accepts two WIDTH-bit operands on a start strobe and shifts them LSB-first through the full-adder cell, one bit per clock. It returns the WIDTH-bit sum and carry-out with a one-cycle done pulse. It sits directly around the team's combinational full-adder stage: it feeds the cell its a/b/carry-in bits and consumes the cell's sum and carry outputs every cycle.

---
 rtl/serial_adder_pkg.sv | 18 +
 rtl/fa_cell.sv | 19 +
 rtl/serial_adder_fsm.sv | 121 ++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared definitions for the bit-serial adder:
//     state_t   - controller state (IDLE, SHIFT, DONE), 2-bit encoding
//     cnt_width - width of the shift counter for a given operand width
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Counter must hold 0..WIDTH-1.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/fa_cell.sv
// fa_cell
//   Purely combinational one-bit full adder.
//   Ports:
//     a, b  - operand bits
//     c     - carry in
//     s     - sum bit
//     car   - carry out
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic car
);

    assign s   = a ^ b ^ c;
    assign car = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder_fsm.sv
// serial_adder_fsm
//   Bit-serial adder: captures two WIDTH-bit operands and a carry-in on an
//   accepted start, then feeds them LSB-first through a single full-adder
//   cell, one bit per clock. {cout,sum} = a + b + cin after WIDTH shift
//   cycles, announced by a one-cycle done pulse.
//   Ports:
//     clk, rst_n - clock, asynchronous active-low reset
//     start      - request strobe, sampled only in IDLE or DONE
//     a, b, cin  - operands and carry-in, captured on an accepted start
//     busy       - high while bits are being shifted
//     done       - one-cycle pulse, sum/cout valid
//     sum, cout  - result, held until the next result is produced
//     ovf        - signed overflow flag (only with SERIAL_ADDER_OVF_EN)
//   Build option: define SERIAL_ADDER_OVF_EN to add the ovf port/register.
module serial_adder_fsm
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             fa_s;
    logic             fa_car;
    logic             last_bit;
    logic [WIDTH-1:0] sum_next;

    fa_cell u_fa (
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .c   (carry),
        .s   (fa_s),
        .car (fa_car)
    );

    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign sum_next = {fa_s, sum_sr[WIDTH-1:1]};

    // sum/cout/ovf are separate result registers loaded on the final shift
    // edge, so a fresh load of the working registers never disturbs them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        carry  <= cin;
                        cnt    <= '0;
                        sum_sr <= '0;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end else begin
                        state  <= IDLE;
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    sum_sr <= sum_next;
                    carry  <= fa_car;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        sum   <= sum_next;
                        cout  <= fa_car;
`ifdef SERIAL_ADDER_OVF_EN
                        // carry into the MSB vs carry out of it
                        ovf   <= fa_car ^ carry;
`endif
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
